// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requester feeding the IF/ID register.
// Handles decode stall via a one-entry hold buffer, redirects with in-flight kill, and flush.
module fetch_stage #(
    parameter logic [31:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]  NOP_INSTR = 32'h0000_0013,
    localparam int unsigned XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_rvalid,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e          r_state;
    logic [XLEN-1:0] r_pcf;
    logic            r_kill;
    logic            r_imem_req;
    logic [XLEN-1:0] r_hold_instr;
    logic [XLEN-1:0] r_hold_pc;
    logic [XLEN-1:0] r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc_plus4_d;
    logic            r_valid_d;

    state_e          w_state_nxt;
    logic [XLEN-1:0] w_pcf_nxt;
    logic            w_kill_nxt;
    logic [XLEN-1:0] w_hold_instr_nxt;
    logic [XLEN-1:0] w_hold_pc_nxt;
    logic [XLEN-1:0] w_instr_d_nxt;
    logic [XLEN-1:0] w_pc_d_nxt;
    logic [XLEN-1:0] w_pc_plus4_d_nxt;
    logic            w_valid_d_nxt;
    logic            w_load;
    logic [XLEN-1:0] w_load_instr;
    logic [XLEN-1:0] w_load_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_unused;

    assign w_pc_plus4    = r_pcf + XLEN'(4);
    assign w_redirect_pc = {PCTargetE[XLEN-1:2], 2'b00};
    assign w_unused      = &{1'b0, PCTargetE[1:0]};

    // Next-state, PC, kill and hold-buffer logic
    always_comb begin
        w_state_nxt      = r_state;
        w_pcf_nxt        = r_pcf;
        w_kill_nxt       = r_kill;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc_nxt    = r_hold_pc;
        w_load           = 1'b0;
        w_load_instr     = imem_rdata;
        w_load_pc        = r_pcf;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_state_nxt = S_WAIT;
                if (PCSrcE) w_kill_nxt = 1'b1;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (PCSrcE || r_kill) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_FETCH;
                    end else if (StallD) begin
                        w_hold_instr_nxt = imem_rdata;
                        w_hold_pc_nxt    = r_pcf;
                        w_state_nxt      = S_HOLD;
                    end else begin
                        w_load      = 1'b1;
                        w_pcf_nxt   = w_pc_plus4;
                        w_state_nxt = S_FETCH;
                    end
                end else if (PCSrcE) begin
                    w_kill_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    w_state_nxt = S_FETCH;
                end else if (!StallD) begin
                    w_load       = 1'b1;
                    w_load_instr = r_hold_instr;
                    w_load_pc    = r_hold_pc;
                    w_pcf_nxt    = w_pc_plus4;
                    w_state_nxt  = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Redirect overrides any sequential PC advance
        if (PCSrcE) w_pcf_nxt = w_redirect_pc;
    end

    // IF/ID register update: flush wins over load, stall is implicit (no load)
    always_comb begin
        w_instr_d_nxt    = r_instr_d;
        w_pc_d_nxt       = r_pc_d;
        w_pc_plus4_d_nxt = r_pc_plus4_d;
        w_valid_d_nxt    = r_valid_d;
        if (FlushD) begin
            w_instr_d_nxt = NOP_INSTR;
            w_valid_d_nxt = 1'b0;
        end else if (w_load) begin
            w_instr_d_nxt    = w_load_instr;
            w_pc_d_nxt       = w_load_pc;
            w_pc_plus4_d_nxt = w_load_pc + XLEN'(4);
            w_valid_d_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pcf        <= RESET_PC;
            r_kill       <= 1'b0;
            r_imem_req   <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pcf        <= w_pcf_nxt;
            r_kill       <= w_kill_nxt;
            r_imem_req   <= (w_state_nxt == S_FETCH);
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
            r_instr_d    <= w_instr_d_nxt;
            r_pc_d       <= w_pc_d_nxt;
            r_pc_plus4_d <= w_pc_plus4_d_nxt;
            r_valid_d    <= w_valid_d_nxt;
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pcf;
    assign InstrD    = r_instr_d;
    assign PCD       = r_pc_d;
    assign PCPlus4D  = r_pc_plus4_d;
    assign ValidD    = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fetch, stall/hold, redirect/kill, flush, PC wrap, async reset.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_rvalid(imem_rvalid),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {a[23:0], 8'h33};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [31:0] a);
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
    endtask

    task automatic quiet();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        PCSrcE      = 1'b0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        PCTargetE = 32'h0;
        quiet();
        step();
        step();
        chk("rst_req",   32'(imem_req), 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcd",   PCD, 32'h0);
        chk("rst_pc4",   PCPlus4D, 32'h0);
        chk("rst_valid", 32'(ValidD), 32'h0);

        // Basic fetch at 0 with 1-cycle memory
        rst = 1'b0;
        #1;
        chk("idle_req", 32'(imem_req), 32'h0);
        step();
        chk("f0_req",  32'(imem_req), 32'h1);
        chk("f0_addr", imem_addr, 32'h0);
        step();
        chk("w0_req", 32'(imem_req), 32'h0);
        respond(32'h0);
        step();
        quiet();
        chk("f0_instr", InstrD, 32'h0050_0093);
        chk("f0_pcd",   PCD, 32'h0);
        chk("f0_pc4",   PCPlus4D, 32'h4);
        chk("f0_valid", 32'(ValidD), 32'h1);
        chk("f4_req",   32'(imem_req), 32'h1);
        chk("f4_addr",  imem_addr, 32'h4);

        // Fetch at 4 with 3-cycle latency
        step();
        step();
        step();
        chk("w4_req",   32'(imem_req), 32'h0);
        chk("w4_instr", InstrD, 32'h0050_0093);
        respond(32'h4);
        step();
        quiet();
        chk("f4_instr", InstrD, mem_word(32'h4));
        chk("f4_pcd",   PCD, 32'h4);
        chk("f8_addr",  imem_addr, 32'h8);

        // Stall during response for addr 8 -> HOLD, stray rvalid ignored
        step();
        respond(32'h8);
        StallD = 1'b1;
        step();
        imem_rvalid = 1'b0;
        chk("h8_instr", InstrD, mem_word(32'h4));
        chk("h8_req",   32'(imem_req), 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        step();
        chk("h8_instr2", InstrD, mem_word(32'h4));
        chk("h8_req2",   32'(imem_req), 32'h0);
        quiet();
        step();
        chk("r8_instr", InstrD, mem_word(32'h8));
        chk("r8_pcd",   PCD, 32'h8);
        chk("r8_pc4",   PCPlus4D, 32'hC);
        chk("f12_req",  32'(imem_req), 32'h1);
        chk("f12_addr", imem_addr, 32'hC);

        // Redirect while WAIT -> in-flight response dropped
        step();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h100;
        step();
        PCSrcE = 1'b0;
        chk("k_addr", imem_addr, 32'h100);
        chk("k_req",  32'(imem_req), 32'h0);
        respond(32'hC);
        step();
        quiet();
        chk("k_instr", InstrD, mem_word(32'h8));
        chk("k_valid", 32'(ValidD), 32'h1);
        chk("k_req2",  32'(imem_req), 32'h1);
        chk("k_addr2", imem_addr, 32'h100);
        step();
        respond(32'h100);
        step();
        quiet();
        chk("t_instr", InstrD, mem_word(32'h100));
        chk("t_pcd",   PCD, 32'h100);
        chk("t_addr",  imem_addr, 32'h104);

        // Redirect and response in the same WAIT cycle, misaligned target
        step();
        respond(32'h104);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h203;
        step();
        quiet();
        chk("s_req",   32'(imem_req), 32'h1);
        chk("s_addr",  imem_addr, 32'h200);
        chk("s_instr", InstrD, mem_word(32'h100));

        // Flush together with stall
        step();
        FlushD = 1'b1;
        StallD = 1'b1;
        step();
        quiet();
        chk("fs_valid", 32'(ValidD), 32'h0);
        chk("fs_instr", InstrD, NOP);
        respond(32'h200);
        step();
        quiet();
        chk("fl_instr", InstrD, mem_word(32'h200));
        chk("fl_valid", 32'(ValidD), 32'h1);
        chk("fl_pc4",   PCPlus4D, 32'h204);
        chk("fl_addr",  imem_addr, 32'h204);

        // Flush on the same cycle a response would load: response lost
        step();
        respond(32'h204);
        FlushD = 1'b1;
        step();
        quiet();
        chk("fx_valid", 32'(ValidD), 32'h0);
        chk("fx_instr", InstrD, NOP);

        // PC wrap and alignment
        step();
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFFE;
        step();
        quiet();
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        respond(32'h208);
        step();
        quiet();
        chk("wr_req",   32'(imem_req), 32'h1);
        chk("wr_addr2", imem_addr, 32'hFFFF_FFFC);
        step();
        respond(32'hFFFF_FFFC);
        step();
        quiet();
        chk("wr_pcd",   PCD, 32'hFFFF_FFFC);
        chk("wr_pc4",   PCPlus4D, 32'h0);
        chk("wr_instr", InstrD, mem_word(32'hFFFF_FFFC));
        chk("wr_next",  imem_addr, 32'h0);

        // Async reset mid-WAIT, stale response after release
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_instr", InstrD, NOP);
        chk("ar_valid", 32'(ValidD), 32'h0);
        chk("ar_pcd",   PCD, 32'h0);
        chk("ar_pc4",   PCPlus4D, 32'h0);
        chk("ar_addr",  imem_addr, 32'h0);
        chk("ar_req",   32'(imem_req), 32'h0);
        step();
        rst = 1'b0;
        respond(32'h0);
        imem_rdata = 32'hBAD0_0001;
        step();
        chk("ar_f_req",   32'(imem_req), 32'h1);
        chk("ar_f_addr",  imem_addr, 32'h0);
        chk("ar_f_valid", 32'(ValidD), 32'h0);
        step();
        quiet();
        chk("ar_w_valid", 32'(ValidD), 32'h0);
        chk("ar_w_instr", InstrD, NOP);
        respond(32'h0);
        step();
        quiet();
        chk("ar_l_instr", InstrD, 32'h0050_0093);
        chk("ar_l_valid", 32'(ValidD), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
